// File: rtl/logic_unit_serial.sv
// Bit-serial logic unit: applies one of eight bitwise ops to W-bit operands, S bits per
// clock, behind a START/BUSY/DONE handshake, with registered OUT/N/Z and accumulate mode.
module logic_unit_serial #(
  parameter int W = 8,
  parameter int S = 2
) (
  input  logic         CLK,
  input  logic         RST_N,
  input  logic         START,
  input  logic [2:0]   OP,
  input  logic         ACC_MODE,
  input  logic [W-1:0] DATA_A,
  input  logic [W-1:0] DATA_B,
  output logic         BUSY,
  output logic         DONE,
  output logic [W-1:0] OUT,
  output logic         N,
  output logic         Z
);
  localparam int L  = W / S;
  localparam int CW = (L > 1) ? $clog2(L) : 1;

  if (W < 2 || (W % S) != 0) begin : g_param_check
    $error("logic_unit_serial: W must be >= 2 and S must divide W");
  end

  typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_DONE} state_t;

  state_t         state_q;
  logic [CW-1:0]  cnt_q;
  logic [W-1:0]   a_q, b_q, res_q, out_q;
  logic [2:0]     op_q;
  logic           n_q, z_q, busy_q, done_q;
  logic [S-1:0]   slice_d;
  logic [W-1:0]   res_d;

  function automatic logic [S-1:0] op_fn(input logic [2:0] op,
                                         input logic [S-1:0] a, input logic [S-1:0] b);
    case (op)
      3'b000:  op_fn = a & b;
      3'b001:  op_fn = a | b;
      3'b010:  op_fn = a ^ b;
      3'b011:  op_fn = ~(a & b);
      3'b100:  op_fn = ~(a | b);
      3'b101:  op_fn = ~(a ^ b);
      3'b110:  op_fn = a;
      default: op_fn = ~a;
    endcase
  endfunction

  // res_d is the shift register with the current slice merged in; on the last slice it is
  // the complete result, so OUT loads straight from it.
  always_comb begin
    slice_d = op_fn(op_q, a_q[cnt_q*S +: S], b_q[cnt_q*S +: S]);
    res_d   = res_q;
    res_d[cnt_q*S +: S] = slice_d;
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      op_q    <= '0;
      res_q   <= '0;
      out_q   <= '0;
      n_q     <= 1'b0;
      z_q     <= 1'b1;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (START) begin
            a_q     <= DATA_A;
            b_q     <= ACC_MODE ? out_q : DATA_B;
            op_q    <= OP;
            cnt_q   <= '0;
            res_q   <= '0;
            busy_q  <= 1'b1;
            state_q <= ST_RUN;
          end
        end
        ST_RUN: begin
          res_q <= res_d;
          cnt_q <= cnt_q + 1'b1;
          if (cnt_q == CW'(L - 1)) begin
            out_q   <= res_d;
            n_q     <= res_d[W-1];
            z_q     <= (res_d == '0);
            done_q  <= 1'b1;
            state_q <= ST_DONE;
          end
        end
        default: begin
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign BUSY = busy_q;
  assign DONE = done_q;
  assign OUT  = out_q;
  assign N    = n_q;
  assign Z    = z_q;
endmodule

// File: tb/tb_logic_unit_serial.sv
// Scoreboard bench for logic_unit_serial: W=8/S=2 directed vectors plus W=16/S=4 and
// W=4/S=4 instances checked against a reference function.
module tb_logic_unit_serial;
  logic CLK = 1'b0;
  logic RST_N;
  always #5 CLK = ~CLK;

  typedef struct { logic [31:0] out; logic n; logic z; } exp_t;
  exp_t q8[$], q16[$], q4[$];
  int checks = 0, errors = 0;

  logic        START, ACC_MODE, BUSY, DONE, N, Z;
  logic [2:0]  OP;
  logic [7:0]  DATA_A, DATA_B, OUT;
  logic        s16_start, s16_acc, s16_busy, s16_done, s16_n, s16_z;
  logic [2:0]  s16_op;
  logic [15:0] s16_a, s16_b, s16_out;
  logic        s4_start, s4_acc, s4_busy, s4_done, s4_n, s4_z;
  logic [2:0]  s4_op;
  logic [3:0]  s4_a, s4_b, s4_out;

  logic_unit_serial #(.W(8), .S(2)) dut (
    .CLK(CLK), .RST_N(RST_N), .START(START), .OP(OP), .ACC_MODE(ACC_MODE),
    .DATA_A(DATA_A), .DATA_B(DATA_B), .BUSY(BUSY), .DONE(DONE), .OUT(OUT), .N(N), .Z(Z));
  logic_unit_serial #(.W(16), .S(4)) dut16 (
    .CLK(CLK), .RST_N(RST_N), .START(s16_start), .OP(s16_op), .ACC_MODE(s16_acc),
    .DATA_A(s16_a), .DATA_B(s16_b), .BUSY(s16_busy), .DONE(s16_done), .OUT(s16_out),
    .N(s16_n), .Z(s16_z));
  logic_unit_serial #(.W(4), .S(4)) dut4 (
    .CLK(CLK), .RST_N(RST_N), .START(s4_start), .OP(s4_op), .ACC_MODE(s4_acc),
    .DATA_A(s4_a), .DATA_B(s4_b), .BUSY(s4_busy), .DONE(s4_done), .OUT(s4_out),
    .N(s4_n), .Z(s4_z));

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] ref_op(input logic [2:0] op, input logic [31:0] a,
                                         input logic [31:0] b);
    case (op)
      3'd0: return a & b;
      3'd1: return a | b;
      3'd2: return a ^ b;
      3'd3: return ~(a & b);
      3'd4: return ~(a | b);
      3'd5: return ~(a ^ b);
      3'd6: return a;
      default: return ~a;
    endcase
  endfunction

  // Monitors: pop an expectation on every DONE cycle.
  always @(negedge CLK) begin
    exp_t e;
    if (DONE === 1'b1) begin
      if (q8.size() == 0) check("dut8 unexpected DONE", 32'd1, 32'd0);
      else begin
        e = q8.pop_front();
        check("dut8 OUT", 32'(OUT), e.out);
        check("dut8 N", 32'(N), 32'(e.n));
        check("dut8 Z", 32'(Z), 32'(e.z));
      end
    end
    if (s16_done === 1'b1) begin
      if (q16.size() == 0) check("dut16 unexpected DONE", 32'd1, 32'd0);
      else begin
        e = q16.pop_front();
        check("dut16 OUT", 32'(s16_out), e.out);
        check("dut16 N", 32'(s16_n), 32'(e.n));
        check("dut16 Z", 32'(s16_z), 32'(e.z));
      end
    end
    if (s4_done === 1'b1) begin
      if (q4.size() == 0) check("dut4 unexpected DONE", 32'd1, 32'd0);
      else begin
        e = q4.pop_front();
        check("dut4 OUT", 32'(s4_out), e.out);
        check("dut4 N", 32'(s4_n), 32'(e.n));
        check("dut4 Z", 32'(s4_z), 32'(e.z));
      end
    end
  end

  // Called right after the accept edge; returns edges from accept to DONE (-1 on timeout).
  task automatic wait_done(input int which, output int lat);
    logic d;
    lat = -1;
    for (int i = 1; i <= 40; i++) begin
      @(negedge CLK);
      d = (which == 8) ? DONE : (which == 16) ? s16_done : s4_done;
      if (d) begin lat = i - 1; break; end
    end
  endtask

  task automatic run8(input string name, input logic [2:0] op, input logic acc,
                      input logic [7:0] a, input logic [7:0] b, input logic [7:0] exp_out);
    int lat;
    q8.push_back('{32'(exp_out), exp_out[7], exp_out == 8'h00});
    @(negedge CLK);
    START = 1'b1; OP = op; ACC_MODE = acc; DATA_A = a; DATA_B = b;
    @(posedge CLK); #1 START = 1'b0;
    check({name, " BUSY after accept"}, 32'(BUSY), 32'd1);
    wait_done(8, lat);
    check({name, " latency"}, 32'(lat), 32'd4);
    @(negedge CLK);
    check({name, " DONE single pulse"}, 32'(DONE), 32'd0);
    check({name, " BUSY idle"}, 32'(BUSY), 32'd0);
  endtask

  task automatic run_var(input int which, input logic [2:0] op, input logic [31:0] a,
                         input logic [31:0] b);
    int lat;
    logic [31:0] r;
    r = ref_op(op, a, b);
    if (which == 16) begin
      r = r & 32'hFFFF;
      q16.push_back('{r, r[15], r == 0});
      @(negedge CLK);
      s16_start = 1'b1; s16_op = op; s16_acc = 1'b0; s16_a = a[15:0]; s16_b = b[15:0];
      @(posedge CLK); #1 s16_start = 1'b0;
      wait_done(16, lat);
      check("dut16 latency", 32'(lat), 32'd4);
    end else begin
      r = r & 32'hF;
      q4.push_back('{r, r[3], r == 0});
      @(negedge CLK);
      s4_start = 1'b1; s4_op = op; s4_acc = 1'b0; s4_a = a[3:0]; s4_b = b[3:0];
      @(posedge CLK); #1 s4_start = 1'b0;
      wait_done(4, lat);
      check("dut4 latency", 32'(lat), 32'd1);
    end
    @(negedge CLK);
  endtask

  logic [7:0] sweep_exp [8] = '{8'h05, 8'hAF, 8'hAA, 8'hFA, 8'h50, 8'h55, 8'hA5, 8'h5A};

  initial begin
    #200000;
    $display("FAIL global timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    int lat;
    RST_N = 1'b0; START = 0; OP = 0; ACC_MODE = 0; DATA_A = 0; DATA_B = 0;
    s16_start = 0; s16_op = 0; s16_acc = 0; s16_a = 0; s16_b = 0;
    s4_start = 0; s4_op = 0; s4_acc = 0; s4_a = 0; s4_b = 0;
    repeat (2) @(negedge CLK);
    RST_N = 1'b1;
    @(negedge CLK);
    check("reset OUT", 32'(OUT), 32'h00);
    check("reset N", 32'(N), 32'd0);
    check("reset Z", 32'(Z), 32'd1);
    check("reset BUSY", 32'(BUSY), 32'd0);
    check("reset DONE", 32'(DONE), 32'd0);

    run8("and first", 3'b000, 1'b0, 8'hF0, 8'h3C, 8'h30);
    for (int i = 0; i < 8; i++)
      run8($sformatf("sweep op%0d", i), 3'(i), 1'b0, 8'hA5, 8'h0F, sweep_exp[i]);

    run8("xor zero", 3'b010, 1'b0, 8'h5A, 8'h5A, 8'h00);
    run8("acc or", 3'b001, 1'b1, 8'h81, 8'hFF, 8'h81);
    run8("acc xor", 3'b010, 1'b1, 8'h81, 8'hFF, 8'h00);

    // Operand stability: inputs churn and START stays high through RUN and DONE.
    q8.push_back('{32'hA5, 1'b1, 1'b0});
    @(negedge CLK);
    START = 1'b1; OP = 3'b101; ACC_MODE = 1'b0; DATA_A = 8'h3C; DATA_B = 8'h66;
    @(posedge CLK); #1;
    lat = -1;
    for (int i = 1; i <= 20; i++) begin
      DATA_A = 8'($urandom); DATA_B = 8'($urandom); OP = 3'($urandom);
      ACC_MODE = 1'($urandom); START = 1'b1;
      @(negedge CLK);
      if (DONE) begin lat = i - 1; break; end
    end
    check("stability latency", 32'(lat), 32'd4);
    @(posedge CLK); #1 START = 1'b0;
    repeat (3) @(negedge CLK);
    check("stability START ignored", 32'(BUSY), 32'd0);

    // Asynchronous reset with the counter at slice 2.
    @(negedge CLK);
    START = 1'b1; OP = 3'b000; ACC_MODE = 1'b0; DATA_A = 8'hFF; DATA_B = 8'hFF;
    @(posedge CLK); #1 START = 1'b0;
    @(posedge CLK);
    @(posedge CLK); #1 RST_N = 1'b0;
    #1;
    check("midreset OUT", 32'(OUT), 32'h00);
    check("midreset Z", 32'(Z), 32'd1);
    check("midreset N", 32'(N), 32'd0);
    check("midreset BUSY", 32'(BUSY), 32'd0);
    check("midreset DONE", 32'(DONE), 32'd0);
    @(posedge CLK); #1 RST_N = 1'b1;
    repeat (6) @(negedge CLK);
    check("midreset stays idle", 32'(BUSY), 32'd0);
    run8("after reset", 3'b001, 1'b0, 8'h12, 8'h40, 8'h52);

    run_var(16, 3'd0, 32'h0000, 32'hFFFF);
    run_var(4, 3'd5, 32'h5, 32'h5);
    for (int i = 0; i < 8; i++) begin
      run_var(16, 3'(i), $urandom, $urandom);
      run_var(4, 3'(i), $urandom, $urandom);
    end

    repeat (3) @(negedge CLK);
    check("scoreboard drained", 32'(q8.size() + q16.size() + q4.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
